// File: rtl/ifa_pkg.sv
// Shared request/grant bus types and default widths for cpucore and mem_responder.
package ifa_pkg;

   localparam int unsigned IFA_ADDR_W = 8;
   localparam int unsigned IFA_DATA_W = 8;

   typedef enum logic [1:0] {
      MODE_READ  = 2'd0,
      MODE_WRITE = 2'd1,
      MODE_RSVD2 = 2'd2,
      MODE_RSVD3 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ACCESS,
      RESP
   } rsp_state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Storage for mem_responder: synchronous write, combinational read on one shared address.
module mem_responder_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the request/grant bus: grants one initiator, completes one access per grant.
module mem_responder
   import ifa_pkg::*;
#(
   parameter int unsigned ADDR_W      = IFA_ADDR_W,
   parameter int unsigned DATA_W      = IFA_DATA_W,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned WR_LAT      = 1,
   parameter int unsigned GNT_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] data_in,
   output logic              gnt,
   output logic              rdy,
   output logic              err,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe
);

   localparam int unsigned LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);
   localparam int unsigned TO_W    = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT);

   rsp_state_e        state, state_d;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
   logic [TO_W-1:0]   to_cnt, to_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   mode_e             mode_q, mode_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gnt_d, rdy_d, err_d, oe_d;
   logic [DATA_W-1:0] dout_d;
   logic [DATA_W-1:0] rdata;
   logic              mem_we;

   // Commit happens on the edge leaving RESP, so a reset during ACCESS never writes.
   assign mem_we = (state == RESP) && (mode_q == MODE_WRITE);

   mem_responder_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         to_cnt   <= '0;
         addr_q   <= '0;
         mode_q   <= MODE_READ;
         wdata_q  <= '0;
         gnt      <= 1'b0;
         rdy      <= 1'b0;
         err      <= 1'b0;
         data_oe  <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_d;
         lat_cnt  <= lat_cnt_d;
         to_cnt   <= to_cnt_d;
         addr_q   <= addr_d;
         mode_q   <= mode_d;
         wdata_q  <= wdata_d;
         gnt      <= gnt_d;
         rdy      <= rdy_d;
         err      <= err_d;
         data_oe  <= oe_d;
         data_out <= dout_d;
      end
   end

   always_comb begin
      state_d   = state;
      lat_cnt_d = lat_cnt;
      to_cnt_d  = to_cnt;
      addr_d    = addr_q;
      mode_d    = mode_q;
      wdata_d   = wdata_q;
      case (state)
         IDLE: begin
            to_cnt_d = '0;
            if (req) state_d = GRANT;
         end
         GRANT: begin
            if (start) begin
               addr_d   = addr;
               mode_d   = mode_e'(mode);
               wdata_d  = data_in;
               to_cnt_d = '0;
               state_d  = ACCESS;
               case (mode_e'(mode))
                  MODE_READ:  lat_cnt_d = LAT_W'(RD_LAT - 1);
                  MODE_WRITE: lat_cnt_d = LAT_W'(WR_LAT - 1);
                  default:    lat_cnt_d = '0;
               endcase
            end else if (!req || (to_cnt == TO_W'(GNT_TIMEOUT - 1))) begin
               to_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               to_cnt_d = to_cnt + 1'b1;
            end
         end
         ACCESS: begin
            if (lat_cnt == '0) state_d = RESP;
            else               lat_cnt_d = lat_cnt - 1'b1;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are the registered image of the state being entered.
   always_comb begin
      gnt_d  = (state_d == GRANT);
      rdy_d  = (state_d == RESP);
      oe_d   = rdy_d && (mode_d == MODE_READ);
      err_d  = rdy_d && (mode_d != MODE_READ) && (mode_d != MODE_WRITE);
      dout_d = oe_d ? rdata : '0;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with hand-computed expectations.
module tb_mem_responder;
   import ifa_pkg::*;

   logic       clk = 1'b0;
   logic       rst, req, start;
   logic [7:0] addr;
   logic [1:0] mode;
   logic [7:0] data_in;
   logic       gnt, rdy, err, data_oe;
   logic [7:0] data_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .RD_LAT      (2),
      .WR_LAT      (1),
      .GNT_TIMEOUT (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .start    (start),
      .addr     (addr),
      .mode     (mode),
      .data_in  (data_in),
      .gnt      (gnt),
      .rdy      (rdy),
      .err      (err),
      .data_out (data_out),
      .data_oe  (data_oe)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full access: grant, start, wait lat edges, check response and return to idle.
   task automatic do_access(input string tag, input logic [7:0] a, input logic [1:0] m,
                            input logic [7:0] d, input int unsigned lat,
                            input logic exp_err, input logic exp_oe, input logic [7:0] exp_dout);
      req = 1'b1;
      tick();
      check({tag, ".gnt"}, gnt, 1'b1);
      start = 1'b1; addr = a; mode = m; data_in = d; req = 1'b0;
      tick();
      start = 1'b0;
      check({tag, ".gnt_off"}, gnt, 1'b0);
      for (int i = 1; i < lat; i++) begin
         check({tag, ".rdy_wait"}, rdy, 1'b0);
         tick();
      end
      if (lat > 1) check({tag, ".rdy_early"}, rdy, 1'b0);
      tick();
      check({tag, ".rdy"}, rdy, 1'b1);
      check({tag, ".err"}, err, exp_err);
      check({tag, ".oe"}, data_oe, exp_oe);
      check({tag, ".dout"}, data_out, exp_dout);
      tick();
      check({tag, ".rdy_end"}, rdy, 1'b0);
      check({tag, ".oe_end"}, data_oe, 1'b0);
      check({tag, ".err_end"}, err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = 1'b0; start = 1'b0; addr = '0; mode = '0; data_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst.gnt", gnt, 1'b0);
      check("rst.rdy", rdy, 1'b0);
      check("rst.err", err, 1'b0);
      check("rst.oe", data_oe, 1'b0);
      check("rst.dout", data_out, 8'h00);

      // 1/2: write then read back
      do_access("wr10", 8'h10, 2'd1, 8'hA5, 1, 1'b0, 1'b0, 8'h00);
      do_access("rd10", 8'h10, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'hA5);

      // 3: grant timeout after 16 GRANT cycles, then re-grant with req held
      req = 1'b1;
      tick();
      check("to.gnt_first", gnt, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("to.gnt_hold", gnt, 1'b1);
      end
      tick();
      check("to.gnt_drop", gnt, 1'b0);
      tick();
      check("to.regnt", gnt, 1'b1);
      req = 1'b0;
      tick();
      check("to.req_fall", gnt, 1'b0);

      // start on the final timeout cycle wins over expiry and req falling
      req = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("prio.gnt_last", gnt, 1'b1);
      start = 1'b1; addr = 8'h30; mode = 2'd1; data_in = 8'h5A; req = 1'b0;
      tick();
      start = 1'b0;
      check("prio.gnt_off", gnt, 1'b0);
      tick();
      check("prio.rdy", rdy, 1'b1);
      tick();
      do_access("rd30", 8'h30, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'h5A);

      // 4: reserved mode flags err and leaves storage alone
      do_access("rsv2", 8'h10, 2'd2, 8'hFF, 1, 1'b1, 1'b0, 8'h00);
      do_access("rsv3", 8'h10, 2'd3, 8'h11, 1, 1'b1, 1'b0, 8'h00);
      do_access("rd10b", 8'h10, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'hA5);

      // 5: reset during ACCESS aborts the write
      do_access("wr20z", 8'h20, 2'd1, 8'h00, 1, 1'b0, 1'b0, 8'h00);
      req = 1'b1;
      tick();
      start = 1'b1; addr = 8'h20; mode = 2'd1; data_in = 8'h3C; req = 1'b0;
      tick();
      start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.gnt", gnt, 1'b0);
      check("abort.rdy", rdy, 1'b0);
      check("abort.err", err, 1'b0);
      check("abort.oe", data_oe, 1'b0);
      check("abort.dout", data_out, 8'h00);
      do_access("rd20", 8'h20, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'h00);

      // 6: start outside GRANT ignored; post-start input changes ignored
      start = 1'b1;
      tick();
      tick();
      check("idle_start.gnt", gnt, 1'b0);
      check("idle_start.rdy", rdy, 1'b0);
      start = 1'b0; req = 1'b1;
      tick();
      check("late.gnt", gnt, 1'b1);
      start = 1'b1; addr = 8'h10; mode = 2'd0; req = 1'b0;
      tick();
      addr = 8'h20; mode = 2'd1; data_in = 8'h77;
      tick();
      check("late.rdy_early", rdy, 1'b0);
      tick();
      check("late.rdy", rdy, 1'b1);
      check("late.oe", data_oe, 1'b1);
      check("late.dout", data_out, 8'hA5);
      start = 1'b0;
      tick();
      check("late.rdy_end", rdy, 1'b0);
      tick();
      check("late.no_extra", rdy, 1'b0);
      do_access("rd20b", 8'h20, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'h00);

      // back-to-back turnaround with req held: rdy, IDLE, then gnt
      req = 1'b1;
      tick();
      start = 1'b1; addr = 8'h10; mode = 2'd1; data_in = 8'hC3;
      tick();
      start = 1'b0;
      tick();
      check("b2b.rdy", rdy, 1'b1);
      tick();
      check("b2b.idle_gnt", gnt, 1'b0);
      tick();
      check("b2b.regnt", gnt, 1'b1);
      req = 1'b0;
      tick();
      do_access("rd10c", 8'h10, 2'd0, 8'h00, 2, 1'b0, 1'b1, 8'hC3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
